// File: rtl/arm_wait_state_ram.sv
// Word-organised synchronous RAM for the ARMv4 core's external memory port.
// It completes each request with a programmable number of wait states and a one-cycle ram_ready pulse.
module arm_wait_state_ram #(
  parameter int    DEPTH       = 1024,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic        oe,
  input  logic [31:0] address,
  input  logic [31:0] ram_data_in,
  input  logic [1:0]  data_size,
  output logic [31:0] ram_data_into_mcu,
  output logic        ram_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [31:0] r_addr, r_wdata;
  logic [1:0]  r_size;
  logic        r_write;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH];

  logic        w_req, w_op_write, w_load_rd, w_rd_in_range, w_wr_in_range, w_commit;
  logic [31:0] w_rd_addr, w_wlane;
  logic [3:0]  w_wmask;

  assign w_req      = cs & (we | oe);
  assign w_op_write = (r_state == S_IDLE) ? we : r_write;
  // With zero wait states the read completes on the sampling edge, before the latch is valid.
  assign w_rd_addr  = (r_state == S_IDLE) ? address : r_addr;

  assign w_rd_in_range = ({2'b00, w_rd_addr[31:2]} < 32'(DEPTH));
  assign w_wr_in_range = ({2'b00, r_addr[31:2]} < 32'(DEPTH));
  assign w_load_rd     = (w_next == S_DONE) && !w_op_write;
  assign w_commit      = (r_state == S_DONE) && r_write && w_wr_in_range;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (WAIT_STATES > 0) begin
            w_next     = S_WAIT;
            w_cnt_next = 4'(WAIT_STATES - 1);
          end else begin
            w_next     = S_DONE;
            w_cnt_next = '0;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) w_next = S_DONE;
        else             w_cnt_next = r_cnt - 4'd1;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_IDLE && w_req) begin
        r_addr  <= address;
        r_wdata <= ram_data_in;
        r_size  <= data_size;
        r_write <= we;
      end
      if (w_load_rd)
        r_rdata <= w_rd_in_range ? r_mem[w_rd_addr[AW+1:2]] : '0;
    end
  end

  // Little-endian lane enables; the source data is replicated so each lane sees its own bytes.
  always_comb begin
    w_wmask = '1;
    w_wlane = r_wdata;
    case (r_size)
      2'b00: begin
        w_wmask = 4'b0001 << r_addr[1:0];
        w_wlane = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_wmask = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{r_wdata[15:0]}};
      end
      default: begin
        w_wmask = '1;
        w_wlane = r_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && w_commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_wmask[i]) r_mem[r_addr[AW+1:2]][8*i +: 8] <= w_wlane[8*i +: 8];
      end
    end
  end

  assign ram_data_into_mcu = r_rdata;
  assign ram_ready         = (r_state == S_DONE);

endmodule

// File: tb/tb_arm_wait_state_ram.sv
// Self-checking bench for arm_wait_state_ram: directed scenarios plus randomized traffic.
// Expected values come from a word-array reference model.
module tb_arm_wait_state_ram;

  localparam int DEPTH = 1024;
  localparam int WS2   = 2;
  localparam int WS0   = 0;
  localparam int REG   = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        cs2, we2, oe2, rdy2;
  logic [31:0] a2, d2, q2;
  logic [1:0]  sz2;
  logic        cs0, we0, oe0, rdy0;
  logic [31:0] a0, d0, q0;
  logic [1:0]  sz0;

  arm_wait_state_ram #(.DEPTH(DEPTH), .WAIT_STATES(WS2), .INIT_FILE("")) dut2 (
    .clk(clk), .rst(rst), .cs(cs2), .we(we2), .oe(oe2), .address(a2),
    .ram_data_in(d2), .data_size(sz2), .ram_data_into_mcu(q2), .ram_ready(rdy2));

  arm_wait_state_ram #(.DEPTH(DEPTH), .WAIT_STATES(WS0), .INIT_FILE("")) dut0 (
    .clk(clk), .rst(rst), .cs(cs0), .we(we0), .oe(oe0), .address(a0),
    .ram_data_in(d0), .data_size(sz0), .ram_data_into_mcu(q0), .ram_ready(rdy0));

  int total = 0;
  int bad   = 0;

  logic [31:0] m2 [REG];
  logic [31:0] m0 [REG];
  logic [31:0] last2 = '0;
  logic [31:0] last0 = '0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                        input logic [31:0] d, input logic [1:0] sz);
    int sh;
    case (sz)
      2'b00: begin
        sh = 8 * int'(a[1:0]);
        return (old & ~(32'hFF << sh)) | ({24'h0, d[7:0]} << sh);
      end
      2'b01: begin
        sh = 16 * int'(a[1]);
        return (old & ~(32'hFFFF << sh)) | ({16'h0, d[15:0]} << sh);
      end
      default: return d;
    endcase
  endfunction

  task automatic drive(input bit s0, input logic c, input logic w, input logic o,
                       input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    if (s0) begin cs0 = c; we0 = w; oe0 = o; a0 = a; d0 = d; sz0 = sz; end
    else    begin cs2 = c; we2 = w; oe2 = o; a2 = a; d2 = d; sz2 = sz; end
  endtask

  // One complete handshake; lat counts edges after the sampling edge until ready, -1 on timeout.
  task automatic access(input bit s0, input logic w, input logic o, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input bit junk,
                        output logic [31:0] q, output int lat, output int extra);
    @(negedge clk);
    drive(s0, 1'b1, w, o, a, d, sz);
    @(posedge clk);
    #1;
    if (junk) drive(s0, 1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom, 2'($urandom));
    else      drive(s0, 1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
    lat = -1;
    q   = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (s0 ? rdy0 : rdy2) begin
        lat = k;
        q   = s0 ? q0 : q2;
        break;
      end
      if (junk) drive(s0, 1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom, 2'($urandom));
    end
    drive(s0, 1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
    @(negedge clk);
    extra = int'(s0 ? rdy0 : rdy2);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (rdy2 !== 1'b0)  begin bad++; $display("FAIL reset_rdy2 got=%b exp=0", rdy2); end
    total++; if (q2 !== 32'h0)   begin bad++; $display("FAIL reset_q2 got=%h exp=0", q2); end
    total++; if (rdy0 !== 1'b0)  begin bad++; $display("FAIL reset_rdy0 got=%b exp=0", rdy0); end
    total++; if (q0 !== 32'h0)   begin bad++; $display("FAIL reset_q0 got=%h exp=0", q0); end
  endtask

  task automatic test_fill;
    logic [31:0] q, v;
    int lat, ex;
    for (int i = 0; i < REG; i++) begin
      v = $urandom; m2[i] = v;
      access(1'b0, 1'b1, 1'b0, 32'(i) << 2, v, 2'b10, 1'b0, q, lat, ex);
      total++; if (lat != WS2) begin bad++; $display("FAIL fill2_lat i=%0d got=%0d exp=%0d", i, lat, WS2); end
      v = $urandom; m0[i] = v;
      access(1'b1, 1'b1, 1'b0, 32'(i) << 2, v, 2'b10, 1'b0, q, lat, ex);
      total++; if (lat != WS0) begin bad++; $display("FAIL fill0_lat i=%0d got=%0d exp=%0d", i, lat, WS0); end
    end
  endtask

  task automatic test_word;
    logic [31:0] q;
    int lat, ex;
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, q, lat, ex);
    m2[4] = 32'hDEADBEEF;
    total++; if (lat != WS2) begin bad++; $display("FAIL word_wr_lat got=%0d exp=%0d", lat, WS2); end
    total++; if (ex != 0)    begin bad++; $display("FAIL word_wr_single_pulse got=%0d exp=0", ex); end
    total++; if (q !== last2) begin bad++; $display("FAIL word_wr_q_hold got=%h exp=%h", q, last2); end
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 2'b10, 1'b0, q, lat, ex);
    last2 = 32'hDEADBEEF;
    total++; if (lat != WS2) begin bad++; $display("FAIL word_rd_lat got=%0d exp=%0d", lat, WS2); end
    total++; if (q !== 32'hDEADBEEF) begin bad++; $display("FAIL word_rd_data got=%h exp=deadbeef", q); end
    total++; if (ex != 0)    begin bad++; $display("FAIL word_rd_single_pulse got=%0d exp=0", ex); end
  endtask

  task automatic test_lanes;
    logic [31:0] q;
    int lat, ex;
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h11223344, 2'b10, 1'b0, q, lat, ex);
    access(1'b0, 1'b1, 1'b0, 32'h22, 32'h000000AA, 2'b00, 1'b0, q, lat, ex);
    access(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 2'b10, 1'b0, q, lat, ex);
    total++; if (q !== 32'h11AA3344) begin bad++; $display("FAIL lane_byte got=%h exp=11aa3344", q); end
    access(1'b0, 1'b1, 1'b0, 32'h21, 32'h0000BEEF, 2'b01, 1'b0, q, lat, ex);
    access(1'b0, 1'b0, 1'b1, 32'h23, 32'h0, 2'b00, 1'b0, q, lat, ex);
    total++; if (q !== 32'h11AABEEF) begin bad++; $display("FAIL lane_half got=%h exp=11aabeef", q); end
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h11223344, 2'b10, 1'b0, q, lat, ex);
    access(1'b0, 1'b1, 1'b0, 32'h21, 32'h0000BEEF, 2'b01, 1'b0, q, lat, ex);
    access(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 2'b10, 1'b0, q, lat, ex);
    total++; if (q !== 32'h1122BEEF) begin bad++; $display("FAIL lane_half_plan got=%h exp=1122beef", q); end
    m2[8] = 32'h1122BEEF;
    last2 = q;
  endtask

  task automatic test_oor;
    logic [31:0] q, exp;
    int lat, ex;
    access(1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h0, 2'b10, 1'b0, q, lat, ex);
    last2 = '0;
    total++; if (q !== 32'h0) begin bad++; $display("FAIL oor_rd_data got=%h exp=0", q); end
    total++; if (lat != WS2)  begin bad++; $display("FAIL oor_rd_lat got=%0d exp=%0d", lat, WS2); end
    access(1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'hA5A5_5A5A, 2'b10, 1'b0, q, lat, ex);
    total++; if (lat != WS2)  begin bad++; $display("FAIL oor_wr_lat got=%0d exp=%0d", lat, WS2); end
    for (int i = 0; i < REG; i++) begin
      access(1'b0, 1'b0, 1'b1, 32'(i) << 2, 32'h0, 2'b10, 1'b0, q, lat, ex);
      exp = m2[i];
      total++; if (q !== exp) begin bad++; $display("FAIL oor_wr_keep idx=%0d got=%h exp=%h", i, q, exp); end
    end
    last2 = m2[REG-1];
  endtask

  task automatic test_reset_wait;
    logic [31:0] q;
    int lat, ex, pulses;
    access(1'b0, 1'b0, 1'b1, 32'h30, 32'h0, 2'b10, 1'b0, q, lat, ex);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h12345678, 2'b10);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last2 = '0;
    last0 = '0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rdy2 === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL rstwait_pulses got=%0d exp=0", pulses); end
    total++; if (q2 !== 32'h0) begin bad++; $display("FAIL rstwait_q got=%h exp=0", q2); end
    access(1'b0, 1'b0, 1'b1, 32'h30, 32'h0, 2'b10, 1'b0, q, lat, ex);
    last2 = m2[12];
    total++; if (q !== m2[12]) begin bad++; $display("FAIL rstwait_mem got=%h exp=%h", q, m2[12]); end
    total++; if (lat != WS2)   begin bad++; $display("FAIL rstwait_idle_lat got=%0d exp=%0d", lat, WS2); end
  endtask

  task automatic test_back_to_back;
    int t1, t2;
    logic [31:0] qa, qb;
    t1 = -1; t2 = -1;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 2'b10);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rdy2 === 1'b1 && t1 < 0) begin
        t1 = cyc; qa = q2; a2 = 32'h4;
      end else if (rdy2 === 1'b1) begin
        t2 = cyc; qb = q2;
        break;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
    last2 = m2[1];
    total++; if (t2 - t1 != WS2 + 2) begin bad++; $display("FAIL b2b_period got=%0d exp=%0d", t2 - t1, WS2 + 2); end
    total++; if (qa !== m2[0]) begin bad++; $display("FAIL b2b_data0 got=%h exp=%h", qa, m2[0]); end
    total++; if (qb !== m2[1]) begin bad++; $display("FAIL b2b_data1 got=%h exp=%h", qb, m2[1]); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ws0_both;
    logic [31:0] q;
    int lat, ex;
    access(1'b1, 1'b0, 1'b1, 32'h8, 32'h0, 2'b10, 1'b0, q, lat, ex);
    last0 = m0[2];
    access(1'b1, 1'b1, 1'b1, 32'h8, 32'hC0FFEE11, 2'b10, 1'b0, q, lat, ex);
    m0[2] = 32'hC0FFEE11;
    total++; if (lat != 0)      begin bad++; $display("FAIL ws0_both_lat got=%0d exp=0", lat); end
    total++; if (q !== last0)   begin bad++; $display("FAIL ws0_both_q_hold got=%h exp=%h", q, last0); end
    total++; if (ex != 0)       begin bad++; $display("FAIL ws0_single_pulse got=%0d exp=0", ex); end
    access(1'b1, 1'b0, 1'b1, 32'h8, 32'h0, 2'b10, 1'b0, q, lat, ex);
    last0 = 32'hC0FFEE11;
    total++; if (q !== 32'hC0FFEE11) begin bad++; $display("FAIL ws0_rd_after got=%h exp=c0ffee11", q); end
  endtask

  task automatic test_random(input bit s0, input int n);
    logic [31:0] q, a, d, exp;
    logic [1:0]  sz;
    logic        w, o;
    int lat, ex, idx, kind, wsx;
    bit inr;
    wsx = s0 ? WS0 : WS2;
    for (int t = 0; t < n; t++) begin
      if ($urandom_range(0, 7) == 0) begin idx = DEPTH + int'($urandom_range(0, 4095)); inr = 1'b0; end
      else begin idx = int'($urandom_range(0, REG - 1)); inr = 1'b1; end
      a = (32'(idx) << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      sz = 2'($urandom);
      kind = int'($urandom_range(0, 3));
      w = (kind >= 2);
      o = (kind != 2);
      access(s0, w, o, a, d, sz, 1'b1, q, lat, ex);
      total++; if (lat != wsx) begin bad++; $display("FAIL rand_lat s0=%0d t=%0d got=%0d exp=%0d", s0, t, lat, wsx); end
      if (w) begin
        exp = s0 ? last0 : last2;
        total++; if (q !== exp) begin bad++; $display("FAIL rand_wr_q s0=%0d t=%0d got=%h exp=%h", s0, t, q, exp); end
        if (inr) begin
          if (s0) m0[idx] = merge(m0[idx], a, d, sz);
          else    m2[idx] = merge(m2[idx], a, d, sz);
        end
      end else begin
        exp = inr ? (s0 ? m0[idx] : m2[idx]) : 32'h0;
        total++; if (q !== exp) begin bad++; $display("FAIL rand_rd s0=%0d t=%0d a=%h got=%h exp=%h", s0, t, a, q, exp); end
        if (s0) last0 = exp; else last2 = exp;
      end
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_word;
    test_lanes;
    test_oor;
    test_reset_wait;
    test_back_to_back;
    test_ws0_both;
    test_random(1'b0, 80);
    test_random(1'b1, 60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
